// File: rtl/dmem_access_unit.sv
// Data-memory access stage feeding the DR data register.
// Single-word READ/WRITE commands complete a fixed MEM_LAT cycles after acceptance.
// Commands arriving while an access is in flight (or both strobes at once) are
// rejected with a one-cycle err pulse.
module dmem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Counter preload: the completing edge is the one where the counter reads zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_rd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                bus_en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req_any_s;
  logic                req_one_s;
  logic                req_both_s;
  logic                complete_s;
  logic                mem_we_d;

  assign req_any_s  = start_rd | start_wr;
  assign req_one_s  = start_rd ^ start_wr;
  assign req_both_s = start_rd & start_wr;

  // Decode the completing edge and the RAM write strobe; no write while reset is held.
  always_comb begin
    complete_s = 1'b0;
    mem_we_d   = 1'b0;
    if ((state_q == ST_WAIT) && (cnt_q == 4'd0)) begin
      complete_s = 1'b1;
      mem_we_d   = ~op_rd_q & ~rst;
    end else begin
      complete_s = 1'b0;
      mem_we_d   = 1'b0;
    end
  end

  // Word RAM: contents survive reset; written only on the completing edge of a write.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Command FSM with registered status outputs and captured command operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_rd_q  <= 1'b0;
      rdata_q  <= '0;
      bus_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_one_s) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_rd_q  <= start_rd;
            cnt_q    <= CNT_INIT;
            state_q  <= ST_WAIT;
            busy_q   <= 1'b1;
            // A new command ends the previous read's bus drive window.
            bus_en_q <= 1'b0;
          end else if (req_both_s) begin
            err_q <= 1'b1;
          end else begin
            err_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Any request seen while busy is dropped, including on the completing edge.
          err_q <= req_any_s;
          if (complete_s) begin
            if (op_rd_q) begin
              rdata_q  <= mem_q[addr_q];
              bus_en_q <= 1'b1;
            end else begin
              bus_en_q <= 1'b0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign bus_en = bus_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
